// File: rtl/bp_word_fifo.sv
// -----------------------------------------------------------------------------
// bp_word_fifo
//
// Single-clock first-word-fall-through word FIFO. It buffers words written by
// the register interface ahead of the SPI master. The engine consumes the head
// word and pops it when it is done with it.
//
// Parameters
//   WIDTH        data word width (default 16)
//   DEPTH        number of entries; must be a power of two and at least 2
//                (default 512)
//
// Ports
//   clock        system clock; all state changes on the rising edge
//   reset_n      asynchronous active-low reset
//   clear        synchronous flush: empties the FIFO and clears the error
//                flags. It overrides push and pop in the same cycle.
//   in_shift     push strobe, one word per cycle
//   in_data      word to push
//   in_full      FIFO holds DEPTH words
//   in_nempty    FIFO holds at least one word
//   out_pop      consume the head word
//   out_data     head word; valid while out_nempty is high. It holds its
//                last value while the FIFO is empty.
//   out_nempty   head word valid
//   level        current word count, 0..DEPTH
//   overflow     sticky: a push was rejected because the FIFO was full
//   underflow    sticky: a pop was issued while the FIFO was empty
//
// Configuration
//   FIFO_ERR_FLAGS_EN  When defined, overflow and underflow are sticky
//                      registers. When undefined, both outputs are tied to 0.
// -----------------------------------------------------------------------------
module bp_word_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 512
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     in_shift,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_full,
    output logic                     in_nempty,
    input  logic                     out_pop,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_nempty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next;
    logic [LW-1:0]    count;
    logic [LW-1:0]    count_next;
    logic [WIDTH-1:0] head_reg;

    logic full;
    logic nempty;
    logic push_ok;
    logic pop_ok;
    logic head_bypass;
    logic head_load;

    // Full and empty come only from the registered count. A pop in the same
    // cycle does not make room for a push into a full FIFO.
    assign full    = (count == FULL_LEVEL);
    assign nempty  = (count != '0);
    assign push_ok = in_shift & ~full;
    assign pop_ok  = out_pop & nempty;

    always_comb begin
        rd_next = rd_ptr;
        if (pop_ok) begin
            rd_next = rd_ptr + AW'(1);
        end

        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + LW'(1);
        end else if (pop_ok && !push_ok) begin
            count_next = count - LW'(1);
        end
    end

    // The head word lives in a register that updates on the same edge as the
    // pointers. When the next head slot is the one being written this cycle
    // (write into an empty FIFO, or a pop that leaves only the new word), the
    // incoming word bypasses the array. Otherwise a pop loads the next stored
    // word. With no next word the register holds its last value.
    assign head_bypass = push_ok && (rd_next == wr_ptr);
    assign head_load   = pop_ok && (count_next != '0);

    // Storage is not reset and is not touched by clear.
    always_ff @(posedge clock) begin
        if (push_ok && !clear) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            head_reg <= '0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_next;
            count  <= count_next;
            if (head_bypass) begin
                head_reg <= in_data;
            end else if (head_load) begin
                head_reg <= mem[rd_next];
            end
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_reg;
    logic underflow_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (clear) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (in_shift && full) begin
                overflow_reg <= 1'b1;
            end
            if (out_pop && !nempty) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    assign in_full    = full;
    assign in_nempty  = nempty;
    assign out_nempty = nempty;
    assign level      = count;
    assign out_data   = head_reg;

endmodule

// File: tb/tb_bp_word_fifo.sv
module tb_bp_word_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 512;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef FIFO_ERR_FLAGS_EN
    localparam logic FLAG_EXP = 1'b1;
`else
    localparam logic FLAG_EXP = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             clear = 1'b0;
    logic             in_shift = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_full;
    logic             in_nempty;
    logic             out_pop = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_nempty;
    logic [LW-1:0]    level;
    logic             overflow;
    logic             underflow;

    int tests  = 0;
    int failed = 0;

    logic [WIDTH-1:0] exp_q[$];

    bp_word_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (clear),
        .in_shift   (in_shift),
        .in_data    (in_data),
        .in_full    (in_full),
        .in_nempty  (in_nempty),
        .out_pop    (out_pop),
        .out_data   (out_data),
        .out_nempty (out_nempty),
        .level      (level),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a pop that will be accepted on the next edge must present the
    // oldest expected word.
    always @(negedge clock) begin
        if (reset_n && out_pop && out_nempty) begin
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL pop_data: got 0x%0h, expected no word", out_data);
            end else begin
                check("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drive one cycle of stimulus; q_it queues the word when the push is
    // expected to be accepted.
    task automatic drive(input logic sh, input logic [WIDTH-1:0] d, input logic pp, input logic q_it);
        in_shift = sh;
        in_data  = d;
        out_pop  = pp;
        if (q_it) exp_q.push_back(d);
        step();
    endtask

    task automatic idle();
        in_shift = 1'b0;
        out_pop  = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_level"},     32'(level),      32'd0);
        check({tag, "_in_full"},   32'(in_full),    32'd0);
        check({tag, "_in_nempty"}, 32'(in_nempty),  32'd0);
        check({tag, "_out_nempty"},32'(out_nempty), 32'd0);
        check({tag, "_out_data"},  32'(out_data),   32'd0);
        check({tag, "_overflow"},  32'(overflow),   32'd0);
        check({tag, "_underflow"}, 32'(underflow),  32'd0);
    endtask

    initial begin
        // Reset
        repeat (3) @(posedge clock);
        #2;
        check_reset_state("rst");
        reset_n = 1'b1;
        step();
        check_reset_state("post_rst");

        // Order and latency
        drive(1'b1, 16'h1111, 1'b0, 1'b1);
        check("lat_nempty", 32'(out_nempty), 32'd1);
        check("lat_data",   32'(out_data),   32'h1111);
        check("lat_level",  32'(level),      32'd1);
        drive(1'b1, 16'h2222, 1'b0, 1'b1);
        drive(1'b1, 16'h3333, 1'b0, 1'b1);
        check("order_level3", 32'(level), 32'd3);
        check("order_head",   32'(out_data), 32'h1111);
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, 1'b0);
        idle();
        check("order_nempty", 32'(out_nempty), 32'd0);
        check("order_level0", 32'(level),      32'd0);
        check("order_hold",   32'(out_data),   32'h3333);

        // Full boundary (pointers start at 3, so the array wraps)
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b1);
        idle();
        check("full_flag",  32'(in_full), 32'd1);
        check("full_level", 32'(level),   32'd512);
        drive(1'b1, 16'hDEAD, 1'b0, 1'b0);
        idle();
        check("full_overflow", 32'(overflow), 32'(FLAG_EXP));
        check("full_level2",   32'(level),    32'd512);
        check("full_head",     32'(out_data), 32'h1000);
        for (int i = 0; i < DEPTH; i++) drive(1'b0, '0, 1'b1, 1'b0);
        idle();
        check("drain_level", 32'(level),   32'd0);
        check("drain_full",  32'(in_full), 32'd0);

        // Empty boundary
        drive(1'b0, '0, 1'b1, 1'b0);
        idle();
        check("empty_underflow", 32'(underflow), 32'(FLAG_EXP));
        check("empty_level",     32'(level),     32'd0);
        drive(1'b1, 16'h0042, 1'b1, 1'b1);
        idle();
        check("empty_pushpop_level", 32'(level),    32'd1);
        check("empty_pushpop_data",  32'(out_data), 32'h0042);

        // Simultaneous push/pop at level 5
        for (int i = 1; i <= 4; i++) drive(1'b1, 16'hA000 + 16'(i), 1'b0, 1'b1);
        idle();
        check("pp5_start", 32'(level), 32'd5);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16'hB000 + 16'(i), 1'b1, 1'b1);
            check("pp5_level", 32'(level), 32'd5);
        end
        idle();

        // Simultaneous push/pop at level 512
        for (int i = 0; i < DEPTH - 5; i++) drive(1'b1, 16'h2000 + 16'(i), 1'b0, 1'b1);
        idle();
        check("pp512_start", 32'(level), 32'd512);
        drive(1'b1, 16'hDEAD, 1'b1, 1'b0);
        idle();
        check("pp512_level", 32'(level),    32'd511);
        check("pp512_full",  32'(in_full),  32'd0);
        check("pp512_ovf",   32'(overflow), 32'(FLAG_EXP));
        for (int i = 0; i < DEPTH - 1; i++) drive(1'b0, '0, 1'b1, 1'b0);
        idle();
        check("pp512_drain", 32'(level), 32'd0);

        // Clear mid-stream with a simultaneous push
        for (int i = 0; i < 7; i++) drive(1'b1, 16'hC000 + 16'(i), 1'b0, 1'b1);
        idle();
        check("clr_start", 32'(level), 32'd7);
        clear = 1'b1;
        exp_q.delete();
        drive(1'b1, 16'hBAD0, 1'b0, 1'b0);
        idle();
        check("clr_level",  32'(level),      32'd0);
        check("clr_nempty", 32'(out_nempty), 32'd0);
        check("clr_ovf",    32'(overflow),   32'd0);
        check("clr_udf",    32'(underflow),  32'd0);
        step();
        check("clr_stays",  32'(level),      32'd0);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 7; i++) drive(1'b1, 16'hD000 + 16'(i), 1'b0, 1'b1);
        idle();
        check("arst_start", 32'(level), 32'd7);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_state("arst");
        #10;
        reset_n = 1'b1;
        step();
        check("arst_release", 32'(level), 32'd0);

        // FIFO works after reset
        drive(1'b1, 16'hE5E5, 1'b0, 1'b1);
        check("post_arst_data", 32'(out_data), 32'hE5E5);
        drive(1'b0, '0, 1'b1, 1'b0);
        idle();
        check("post_arst_level", 32'(level), 32'd0);
        step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
